// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: CPU <-> AXI4-Lite UART bridge with RX/TX byte FIFOs.
// RX FIFO is filled by polling the UART RX register; TX FIFO is drained
// to the UART TX register with bounded retries on error responses.
// Optional build macro UART_BRIDGE_TX_PRELOAD_EN: reset leaves 8'hAA in
// the TX FIFO so it goes out first as a boot handshake byte.
module uart_fifo_bridge #(
  parameter int unsigned RX_AW     = 8,
  parameter int unsigned TX_AW     = 9,
  parameter logic [31:0] RX_ADDR   = 32'h0,
  parameter logic [31:0] TX_ADDR   = 32'h4,
  parameter int unsigned MAX_RETRY = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           rd_req,
  output logic           rd_done,
  output logic [31:0]    rd_data,
  input  logic           wr_req,
  output logic           wr_done,
  input  logic [31:0]    wr_data,
  output logic [RX_AW:0] rx_count,
  output logic [TX_AW:0] tx_count,
  output logic           tx_err,
  output logic [31:0]    m_araddr,
  output logic           m_arvalid,
  input  logic           m_arready,
  input  logic [31:0]    m_rdata,
  input  logic [1:0]     m_rresp,
  input  logic           m_rvalid,
  output logic           m_rready,
  output logic [31:0]    m_awaddr,
  output logic           m_awvalid,
  input  logic           m_awready,
  output logic [31:0]    m_wdata,
  output logic [3:0]     m_wstrb,
  output logic           m_wvalid,
  input  logic           m_wready,
  input  logic [1:0]     m_bresp,
  input  logic           m_bvalid,
  output logic           m_bready
);

  localparam int unsigned RCW = $clog2(MAX_RETRY + 1);

`ifdef UART_BRIDGE_TX_PRELOAD_EN
  localparam logic [TX_AW:0] TX_WPTR_RST = (TX_AW+1)'(1);
`else
  localparam logic [TX_AW:0] TX_WPTR_RST = '0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_WR_ADDR, S_WR_RESP, S_RD_ADDR, S_RD_DATA} state_e;

  state_e          state_q, state_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic [RCW-1:0]  retry_q, retry_d;
  logic            tx_err_q, tx_err_d;
  logic            rd_done_q, rd_done_d;
  logic            wr_done_q, wr_done_d;
  logic [31:0]     rd_data_q, rd_data_d;
  logic [RX_AW:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [TX_AW:0]  tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [7:0]      rx_mem [2**RX_AW];
  logic [7:0]      tx_mem [2**TX_AW];
  logic            rx_push, rx_pop, tx_push, tx_pop;
  logic            rx_empty, rx_full, tx_empty, tx_full;
  logic            unused_bits;

  assign unused_bits = ^{m_rdata[31:8], m_rresp[0], m_bresp[0], wr_data[31:8]};

  assign rx_count = rx_wptr_q - rx_rptr_q;
  assign tx_count = tx_wptr_q - tx_rptr_q;
  assign rx_empty = (rx_count == '0);
  assign tx_empty = (tx_count == '0);
  // count never exceeds depth, so its top bit alone marks full
  assign rx_full  = rx_count[RX_AW];
  assign tx_full  = tx_count[TX_AW];

  assign rx_push = (state_q == S_RD_DATA) && m_rvalid && !m_rresp[1];
  assign rx_pop  = rd_req && !rd_done_q && !rx_empty;
  assign tx_push = wr_req && !wr_done_q && !tx_full;

  assign m_araddr = RX_ADDR;
  assign m_awaddr = TX_ADDR;
  assign m_wstrb  = 4'b0001;
  assign m_wdata  = {24'h0, tx_mem[tx_rptr_q[TX_AW-1:0]]};
  assign rd_done  = rd_done_q;
  assign wr_done  = wr_done_q;
  assign rd_data  = rd_data_q;
  assign tx_err   = tx_err_q;

  // RX storage write port
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr_q[RX_AW-1:0]] <= m_rdata[7:0];
  end

  // TX storage write port (plus boot byte when preloading)
  always_ff @(posedge clk) begin
`ifdef UART_BRIDGE_TX_PRELOAD_EN
    if (!rstn) tx_mem[0] <= 8'hAA;
    else if (tx_push) tx_mem[tx_wptr_q[TX_AW-1:0]] <= wr_data[7:0];
`else
    if (tx_push) tx_mem[tx_wptr_q[TX_AW-1:0]] <= wr_data[7:0];
`endif
  end

  // CPU side handshakes and FIFO pointer updates
  always_comb begin
    rd_done_d = rx_pop;
    wr_done_d = tx_push;
    rd_data_d = rx_pop ? {24'h0, rx_mem[rx_rptr_q[RX_AW-1:0]]} : rd_data_q;
    rx_wptr_d = rx_push ? rx_wptr_q + (RX_AW+1)'(1) : rx_wptr_q;
    rx_rptr_d = rx_pop  ? rx_rptr_q + (RX_AW+1)'(1) : rx_rptr_q;
    tx_wptr_d = tx_push ? tx_wptr_q + (TX_AW+1)'(1) : tx_wptr_q;
    tx_rptr_d = tx_pop  ? tx_rptr_q + (TX_AW+1)'(1) : tx_rptr_q;
  end

  // AXI master FSM: next state, channel outputs, retry bookkeeping
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    retry_d   = retry_q;
    tx_err_d  = tx_err_q;
    tx_pop    = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (!tx_empty)     state_d = S_WR_ADDR;
        else if (!rx_full) state_d = S_RD_ADDR;
      end
      S_WR_ADDR: begin
        m_awvalid = !aw_done_q;
        m_wvalid  = !w_done_q;
        if (m_awready) aw_done_d = 1'b1;
        if (m_wready)  w_done_d  = 1'b1;
        if ((aw_done_q || m_awready) && (w_done_q || m_wready)) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          if (!m_bresp[1]) begin
            tx_pop  = 1'b1;
            retry_d = '0;
            state_d = S_IDLE;
          end else if (retry_q == RCW'(MAX_RETRY - 1)) begin
            tx_pop   = 1'b1;
            retry_d  = '0;
            tx_err_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            retry_d   = retry_q + RCW'(1);
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WR_ADDR;
          end
        end
      end
      S_RD_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        m_rready = 1'b1;
        if (m_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      retry_q   <= '0;
      tx_err_q  <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      rd_data_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      tx_wptr_q <= TX_WPTR_RST;
      tx_rptr_q <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      retry_q   <= retry_d;
      tx_err_q  <= tx_err_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      rd_data_q <= rd_data_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
    end
  end

endmodule
